// File: rtl/pipe_reg_ctrl.sv
// pipe_reg_ctrl: sequencing controller for the IF/ID, ID/EX, EX/MEM, MEM/WB
// pipeline registers and the PC. It converts load-use, memory-wait,
// taken-branch and halt events into per-register write enables and flushes.
// Enables and flushes are combinational from state, wait counter and inputs.
// Optional feature: define PIPE_REG_CTRL_PERF_EN to build the saturating
// stall_cycles / flush_count performance counters. Otherwise both are 0.
module pipe_reg_ctrl #(
  parameter int unsigned MEM_WAIT  = 2,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_use,
  input  logic                 mem_req,
  input  logic                 branch_taken,
  input  logic                 halt,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  // Wait counter only needs to hold MEM_WAIT-2. The width stays at least 1 bit.
  localparam int unsigned   WW          = (MEM_WAIT > 1) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [WW-1:0] WCNT_LOAD   = WW'((MEM_WAIT > 1) ? (MEM_WAIT - 32'd2) : 32'd0);
  localparam bit            MEM_EN      = (MEM_WAIT > 0);
  localparam bit            SINGLE_WAIT = (MEM_WAIT == 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          skip_q, skip_d;

  // {pc, if_id, id_ex, ex_mem, mem_wb} enables and {if_id, id_ex} flushes before reset gating
  logic [4:0]    en_s;
  logic [1:0]    fl_s;
  logic          mem_take_s;

  // A memory request stalls only if memory is multi-cycle and this is not the release cycle.
  assign mem_take_s = mem_req & MEM_EN & ~skip_q;

  // State, wait counter and skip flag registers. Reset abandons any pending wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      skip_q  <= skip_d;
    end
  end

  // Next-state logic and the priority mux for enables and flushes (halt > mem > branch > load-use).
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    skip_d  = skip_q;
    en_s    = 5'b00000;
    fl_s    = 2'b00;
    case (state_q)
      ST_RUN: begin
        skip_d = 1'b0;
        if (halt) begin
          state_d = ST_HALTED;
        end else if (mem_take_s) begin
          if (SINGLE_WAIT) begin
            skip_d = 1'b1;
          end else begin
            state_d = ST_MEMWAIT;
            wcnt_d  = WCNT_LOAD;
          end
        end else if (branch_taken) begin
          // PC takes the target and both wrong-path instructions are squashed.
          en_s = 5'b11111;
          fl_s = 2'b11;
        end else if (load_use) begin
          // Hold PC and IF/ID, insert one bubble into ID/EX.
          en_s = 5'b00111;
          fl_s = 2'b01;
        end else begin
          en_s = 5'b11111;
        end
      end
      ST_MEMWAIT: begin
        if (wcnt_q == '0) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q - WW'(1'b1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = '0;
        skip_d  = 1'b0;
      end
    endcase
  end

  assign pc_en       = en_s[4] & ~reset;
  assign if_id_en    = en_s[3] & ~reset;
  assign id_ex_en    = en_s[2] & ~reset;
  assign ex_mem_en   = en_s[1] & ~reset;
  assign mem_wb_en   = en_s[0] & ~reset;
  assign if_id_flush = fl_s[1] & ~reset;
  assign id_ex_flush = fl_s[0] & ~reset;
  assign busy        = (state_q != ST_RUN) & ~reset;

`ifdef PIPE_REG_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;
  logic                 stall_ev_s;
  logic                 flush_ev_s;

  // A frozen cycle is any cycle with the PC held, except once halted.
  assign stall_ev_s = ~pc_en & (state_q != ST_HALTED);
  assign flush_ev_s = (state_q == ST_RUN) & ~halt & ~mem_take_s & branch_taken & ~reset;

  // Saturating increments for both performance counters.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_ev_s && (stall_q != '1)) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end else begin
      stall_d = stall_q;
    end
    if (flush_ev_s && (flush_q != '1)) begin
      flush_d = flush_q + CNT_WIDTH'(1);
    end else begin
      flush_d = flush_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/pipe_reg_ctrl.md
# pipe_reg_ctrl

Sequencing controller for the pipelined CPU's four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It turns hazard and event inputs into per-register write enables and flush strobes:

- load-use stalls;
- multi-cycle memory waits;
- taken-branch squashes;
- halt.

It sits beside the datapath. Its enables drive each register's write_en, and its flushes clear a register's contents at the next clock edge.

## Interface
Parameters:
- MEM_WAIT, 2, total freeze cycles per data-memory access (0 = memory is single-cycle, mem_req ignored)
- CNT_WIDTH, 32, width of performance counters

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- load_use  input  1  ID-stage load-use hazard detected this cycle
- mem_req  input  1  MEM-stage instruction accesses data memory this cycle
- branch_taken  input  1  EX-stage branch resolved taken this cycle
- halt  input  1  halt instruction reached MEM stage
- pc_en  output  1  PC write enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  pipeline register write enables
- if_id_flush, id_ex_flush  output  1 each  clear register to bubble at next edge (only effective with matching enable high)
- busy  output  1  state != RUN
- stall_cycles  output  CNT_WIDTH  frozen-cycle count (see Configuration)
- flush_count  output  CNT_WIDTH  taken-branch flush count (see Configuration)

## Operation
- States: RUN, MEMWAIT, HALTED. Internal down-counter wcnt is sized to hold MEM_WAIT.
- Outputs are combinational from state, wcnt and inputs.
- Input priority in RUN: halt > mem_req > branch_taken > load_use.

RUN:
- halt=1: all enables 0, flushes 0; next state HALTED.
- mem_req=1, MEM_WAIT>0: all enables 0.
  - MEM_WAIT=1: stays RUN. The following cycle ignores mem_req once (internal skip flag) and enables all.
  - MEM_WAIT>1: next state MEMWAIT, wcnt<=MEM_WAIT-2.
- branch_taken=1: all enables 1, if_id_flush=1, id_ex_flush=1 (PC loads target, two wrong-path instructions squashed). Overrides a simultaneous load_use.
- load_use=1: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1 (one bubble), ex_mem_en=1, mem_wb_en=1.
- Otherwise: all enables 1, flushes 0.

MEMWAIT:
- All enables 0, flushes 0.
- When wcnt==0: next state RUN and skip flag set. On the next RUN cycle, mem_req is ignored and all other inputs are evaluated normally with enables released.
- Otherwise wcnt decrements.
- All inputs ignored, including halt. halt is re-evaluated on return to RUN.

HALTED:
- All enables 0, flushes 0.
- Exits only via reset.

Reset:
- While reset is high: all enables 0, flushes 0, busy 0.
- State RUN, wcnt 0, skip flag 0, counters 0.
- Reset mid-MEMWAIT abandons the wait immediately.

## Timing
- Load-use: exactly 1 stall cycle; the hazard input must deassert once the bubble propagates.
- Memory access starting in cycle T with MEM_WAIT=N>0: enables low in cycles T..T+N-1, high in T+N.
- Branch flush: same cycle as branch_taken; registers clear at the following edge.
- halt in cycle T: enables low from T onward; busy=1 from T+1.
- No input-to-output pipelining; combinational depth is one state decode plus priority mux.

## Configuration
- PIPE_REG_CTRL_PERF_EN defined:
  - stall_cycles increments every cycle pc_en==0 while state != HALTED and reset low.
  - flush_count increments every cycle branch_taken causes a flush.
  - Both saturate at all-ones.
- Undefined: both outputs tied to 0, no counter flops.

## Test plan
- Reset asserted mid-MEMWAIT (MEM_WAIT=4, wait cycle 2) -> enables 0 during reset; after release state RUN, busy 0, all enables 1 with idle inputs.
- load_use=1 for one cycle in RUN -> that cycle pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1; next cycle all enables 1; stall_cycles=1 with macro.
- MEM_WAIT=3, mem_req held high from cycle 10 -> enables 0 in cycles 10,11,12, all 1 in cycle 13; busy 1 in cycles 11,12; stall_cycles=3.
- branch_taken=1 and load_use=1 in same cycle -> all enables 1, if_id_flush=id_ex_flush=1, pc_en=1; flush_count=1.
- halt=1 during MEMWAIT (MEM_WAIT=2) -> ignored until release cycle; halt still high there -> HALTED, enables 0 indefinitely, stall_cycles stops counting.
- MEM_WAIT=0, mem_req=1 every cycle for 5 cycles -> no stall, all enables 1, busy 0.
